// File: rtl/ua_arbiter_pkg.sv
// Shared definitions for the UA arbiter: FSM states, op codes and defaults.
package ua_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_BCAST = 2'd3
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_LDA = 3'b011;
   localparam logic [2:0] OP_STA = 3'b100;

   localparam int NUM_RS_DEF  = 4;
   localparam int TIMEOUT_DEF = 15;

   function automatic logic op_is_valid(input logic [2:0] op);
      return (op >= OP_ADD) && (op <= OP_STA);
   endfunction

endpackage

// File: rtl/ua_arbiter_if.sv
// Station, UA and common-data-bus signals shared by the arbiter and its neighbours.
interface ua_arbiter_if import ua_arbiter_pkg::*; #(
   parameter int NUM_RS = NUM_RS_DEF
) ();

   logic [NUM_RS-1:0]    req;
   logic [3*NUM_RS-1:0]  rs_tag;
   logic [3*NUM_RS-1:0]  rs_op;
   logic [16*NUM_RS-1:0] rs_vj;
   logic [16*NUM_RS-1:0] rs_vk;
   logic [NUM_RS-1:0]    grant;

   logic                 ua_start;
   logic [2:0]           ua_id;
   logic [2:0]           ua_op;
   logic [15:0]          ua_dado1;
   logic [15:0]          ua_dado2;
   logic [18:0]          ua_resultado;
   logic                 ua_confirmacao;
   logic                 ua_busy;

   logic                 cdb_valid;
   logic [2:0]           cdb_tag;
   logic [15:0]          cdb_dado;
   logic                 cdb_ready;

   logic                 err_timeout;
   logic                 err_op;

   modport slave (
      input  req, rs_tag, rs_op, rs_vj, rs_vk,
      input  ua_resultado, ua_confirmacao, ua_busy, cdb_ready,
      output grant, ua_start, ua_id, ua_op, ua_dado1, ua_dado2,
      output cdb_valid, cdb_tag, cdb_dado, err_timeout, err_op
   );

   modport master (
      output req, rs_tag, rs_op, rs_vj, rs_vk,
      output ua_resultado, ua_confirmacao, ua_busy, cdb_ready,
      input  grant, ua_start, ua_id, ua_op, ua_dado1, ua_dado2,
      input  cdb_valid, cdb_tag, cdb_dado, err_timeout, err_op
   );

endinterface

// File: rtl/ua_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after i_ptr, wrapping.
module ua_rr_pick import ua_arbiter_pkg::*; #(
   parameter int NUM_RS = NUM_RS_DEF,
   localparam int IW    = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
   input  logic [NUM_RS-1:0] i_req,
   input  logic [IW-1:0]     i_ptr,
   output logic [NUM_RS-1:0] o_grant,
   output logic [IW-1:0]     o_idx,
   output logic              o_any
);

   localparam int SW = IW + 1;

   // Scan offsets 1..NUM_RS so the previous winner has lowest priority.
   always_comb begin
      logic [SW-1:0] w_sum;
      logic [IW-1:0] w_j;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_sum   = '0;
      w_j     = '0;
      for (int k = 1; k <= NUM_RS; k++) begin
         w_sum = {1'b0, i_ptr} + SW'(k);
         w_j   = (w_sum >= SW'(NUM_RS)) ? IW'(w_sum - SW'(NUM_RS)) : IW'(w_sum);
         if (!o_any && i_req[w_j]) begin
            o_any      = 1'b1;
            o_idx      = w_j;
            o_grant[w_j] = 1'b1;
         end else begin
            o_any = o_any;
         end
      end
   end

endmodule

// File: rtl/ua_arbiter.sv
// Shares one UA among NUM_RS reservation stations and broadcasts each result on the CDB.
module ua_arbiter import ua_arbiter_pkg::*; #(
   parameter int NUM_RS  = NUM_RS_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input logic         CLK,
   input logic         CLR,
   ua_arbiter_if.slave bus
);

   localparam int IW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t              r_state;
   state_t              w_nxt;
   logic [IW-1:0]       r_last;
   logic [TW-1:0]       r_tmo;
   logic [NUM_RS-1:0]   r_grant;
   logic                r_ua_start;
   logic [2:0]          r_ua_id;
   logic [2:0]          r_ua_op;
   logic [15:0]         r_ua_d1;
   logic [15:0]         r_ua_d2;
   logic                r_cdb_valid;
   logic [2:0]          r_cdb_tag;
   logic [15:0]         r_cdb_dado;
   logic                r_err_tmo;
   logic                r_err_op;

   logic [NUM_RS-1:0]   w_pick_grant;
   logic [IW-1:0]       w_pick_idx;
   logic                w_pick_any;
   logic [2:0]          w_sel_op;
   logic                w_take;
   logic                w_issue;
   logic                w_bad;
   logic                w_done;
   logic                w_tmo_hit;
   logic                w_drop;
   logic                w_unused;

   ua_rr_pick #(.NUM_RS(NUM_RS)) u_pick (
      .i_req   (bus.req),
      .i_ptr   (r_last),
      .o_grant (w_pick_grant),
      .o_idx   (w_pick_idx),
      .o_any   (w_pick_any)
   );

   assign w_sel_op = bus.rs_op[3*int'(w_pick_idx) +: 3];
   // The UA's upper result bits carry no meaning for the CDB.
   assign w_unused = &{1'b0, bus.ua_resultado[18:16]};

   // Next-state and one-cycle control strobes.
   always_comb begin
      w_nxt     = r_state;
      w_take    = 1'b0;
      w_issue   = 1'b0;
      w_bad     = 1'b0;
      w_done    = 1'b0;
      w_tmo_hit = 1'b0;
      w_drop    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_any) begin
               w_take = 1'b1;
               if (op_is_valid(w_sel_op)) begin
                  w_issue = 1'b1;
                  w_nxt   = ST_ISSUE;
               end else begin
                  w_bad = 1'b1;
                  w_nxt = ST_IDLE;
               end
            end else begin
               w_nxt = ST_IDLE;
            end
         end
         ST_ISSUE: w_nxt = ST_WAIT;
         ST_WAIT: begin
            if (bus.ua_confirmacao && !bus.ua_busy) begin
               w_done = 1'b1;
               w_nxt  = ST_BCAST;
            end else if (r_tmo == TW'(TIMEOUT - 1)) begin
               w_tmo_hit = 1'b1;
               w_nxt     = ST_IDLE;
            end else begin
               w_nxt = ST_WAIT;
            end
         end
         ST_BCAST: begin
            if (bus.cdb_ready) begin
               w_drop = 1'b1;
               if (w_pick_any) begin
                  w_take = 1'b1;
                  if (op_is_valid(w_sel_op)) begin
                     w_issue = 1'b1;
                     w_nxt   = ST_ISSUE;
                  end else begin
                     w_bad = 1'b1;
                     w_nxt = ST_IDLE;
                  end
               end else begin
                  w_nxt = ST_IDLE;
               end
            end else begin
               w_nxt = ST_BCAST;
            end
         end
         default: w_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nxt;
      end
   end

   // Datapath, handshake outputs and sticky error flags.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_last      <= IW'(NUM_RS - 1);
         r_tmo       <= '0;
         r_grant     <= '0;
         r_ua_start  <= 1'b0;
         r_ua_id     <= 3'd0;
         r_ua_op     <= 3'd0;
         r_ua_d1     <= 16'd0;
         r_ua_d2     <= 16'd0;
         r_cdb_valid <= 1'b0;
         r_cdb_tag   <= 3'd0;
         r_cdb_dado  <= 16'd0;
         r_err_tmo   <= 1'b0;
         r_err_op    <= 1'b0;
      end else begin
         r_grant    <= w_take ? w_pick_grant : '0;
         r_ua_start <= w_issue;
         if (w_take) begin
            r_last <= w_pick_idx;
         end
         if (w_issue) begin
            r_ua_id <= bus.rs_tag[3*int'(w_pick_idx) +: 3];
            r_ua_op <= w_sel_op;
            r_ua_d1 <= bus.rs_vj[16*int'(w_pick_idx) +: 16];
            r_ua_d2 <= bus.rs_vk[16*int'(w_pick_idx) +: 16];
         end
         r_tmo <= (r_state == ST_WAIT && !w_done && !w_tmo_hit) ? r_tmo + TW'(1) : '0;
         if (w_done) begin
            r_cdb_valid <= 1'b1;
            r_cdb_tag   <= r_ua_id;
            r_cdb_dado  <= bus.ua_resultado[15:0];
         end else if (w_drop) begin
            r_cdb_valid <= 1'b0;
         end
         if (w_tmo_hit) begin
            r_err_tmo <= 1'b1;
         end
         if (w_bad) begin
            r_err_op <= 1'b1;
         end
      end
   end

   assign bus.grant       = r_grant;
   assign bus.ua_start    = r_ua_start;
   assign bus.ua_id       = r_ua_id;
   assign bus.ua_op       = r_ua_op;
   assign bus.ua_dado1    = r_ua_d1;
   assign bus.ua_dado2    = r_ua_d2;
   assign bus.cdb_valid   = r_cdb_valid;
   assign bus.cdb_tag     = r_cdb_tag;
   assign bus.cdb_dado    = r_cdb_dado;
   assign bus.err_timeout = r_err_tmo;
   assign bus.err_op      = r_err_op;

endmodule

// File: doc/ua_arbiter.md
UA_ARBITER -- requirements
Module: ua_arbiter

Interface
REQ-001 SHALL have parameter NUM_RS, default 4, the number of reservation stations sharing one UA.
REQ-002 SHALL have parameter TIMEOUT, default 15, the maximum cycles to wait for UA completion.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state on posedge CLK.
REQ-004 SHALL have port CLR, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port req, input, NUM_RS, per-station request, level, held until granted.
REQ-006 SHALL have port rs_tag, input, 3*NUM_RS, per-station result tag (ID); slice i belongs to station i.
REQ-007 SHALL have port rs_op, input, 3*NUM_RS, per-station op (001 add, 010 sub, 011 load addr, 100 store addr).
REQ-008 SHALL have ports rs_vj and rs_vk, input, 16*NUM_RS each, per-station operands.
REQ-009 SHALL have port grant, output, NUM_RS, one-hot acknowledge to the station whose operands were captured.
REQ-010 SHALL have ports ua_start (1), ua_id (3), ua_op (3), ua_dado1 (16), ua_dado2 (16), outputs, driving the UA.
REQ-011 SHALL have ports ua_resultado (19), ua_confirmacao (1), ua_busy (1), inputs, from the UA.
REQ-012 SHALL have ports cdb_valid (1), cdb_tag (3), cdb_dado (16), outputs, result broadcast; cdb_ready (1), input, broadcast accept.
REQ-013 SHALL have ports err_timeout and err_op, outputs, 1 each, sticky error flags.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT, BCAST.
REQ-015 IDLE: if any req with a valid op, SHALL pick one station round-robin, capture its tag/op/vj/vk, assert grant bit and ua_start for exactly one cycle (the ISSUE cycle), go to ISSUE.
REQ-016 Round-robin SHALL search from (last granted + 1) mod NUM_RS upward; the last-granted pointer updates only on grant.
REQ-017 A picked station with op outside 001..100 SHALL be granted, not issued, set err_op, and the arbiter stays in IDLE.
REQ-018 ISSUE SHALL last one cycle and then go to WAIT unconditionally; ua_start SHALL be 0 outside ISSUE.
REQ-019 WAIT SHALL complete on ua_confirmacao=1 and ua_busy=0; confirmacao seen during ISSUE SHALL be ignored (stale level from previous op).
REQ-020 On completion SHALL latch ua_resultado[15:0] into cdb_dado, the captured tag into cdb_tag (ua_resultado[18:16] ignored), assert cdb_valid, and go to BCAST.
REQ-021 WAIT lasting TIMEOUT cycles without completion SHALL set err_timeout, return to IDLE, and broadcast nothing.
REQ-022 BCAST SHALL hold cdb_valid/tag/dado stable until cdb_ready=1; on that edge SHALL drop cdb_valid and go to IDLE, or directly to ISSUE if a valid req is pending (arbitration per REQ-015/016).
REQ-023 ua_id, ua_op, ua_dado1, ua_dado2 SHALL stay stable from ISSUE through the completion of WAIT.
REQ-024 Latency SHALL be: req seen at edge k -> ua_start/grant high after k -> cdb_valid high after edge k+4 (UA's 3-cycle operation).
REQ-025 Requests arriving in any state other than IDLE/BCAST-accept SHALL wait; grant is never issued twice for one capture.
REQ-026 err_timeout and err_op SHALL clear only on reset.

Reset
REQ-027 CLR low SHALL immediately force state IDLE, all outputs 0, last-granted pointer NUM_RS-1 (station 0 first priority), timeout counter 0.
REQ-028 Reset mid-operation SHALL abandon the in-flight op with no broadcast; the UA is reset in the same domain.

Structure
REQ-029 State encoding, op codes (001..100), NUM_RS and TIMEOUT defaults SHALL live in a shared package.
REQ-030 Round-robin selection SHALL be one sub-module, ua_rr_pick (req vector + pointer in, one-hot grant + index out, combinational).

Verification
REQ-031 Single op: req=0001, op=001, vj=0x0005, vk=0x0003, tag=2 -> grant=0001 one cycle, cdb_valid after 4 edges with tag=2, dado=0x0008.
REQ-032 Sub wrap: op=010, vj=0x0000, vk=0x0001 -> cdb_dado=0xFFFF.
REQ-033 Fairness: req=1111 held, cdb_ready=1 -> grants in order 0001,0010,0100,1000,0001.
REQ-034 Backpressure: cdb_ready=0 for 6 cycles in BCAST -> cdb_valid/tag/dado stable, no new grant; cdb_ready=1 -> pending req issued next cycle.
REQ-035 Stuck UA (ua_busy forced 1) -> err_timeout set after 15 WAIT cycles, state IDLE, no cdb_valid.
REQ-036 Reset mid-WAIT (CLR low one cycle) -> all outputs 0 immediately, no broadcast; next req to station 0 wins first.
